reg_cmd_sequencer: RTL

//  Upstream control stage for the 4-bit FunSel register (clear/load/dec/inc).
//  - Accepts one command per valid/ready handshake.
//  - Drives FunSel, data_in and enable as timed one-cycle pulses.
//  - Repeats INC/DEC a programmable number of times.
//  - Keeps a shadow copy of the downstream register value for status and debug.

---
 rtl/reg_cmd_sequencer_if.sv | 29 ++
 rtl/reg_cmd_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/reg_cmd_sequencer_if.sv
// Command/response bundle between a command source and reg_cmd_sequencer.
// The master side issues commands; the slave side drives the FunSel pulse outputs and status.
interface reg_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [1:0]       FunSel;
  logic [WIDTH-1:0] data_in;
  logic             enable;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shadow;
  logic             sat;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, FunSel, data_in, enable, busy, done, shadow, sat
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, FunSel, data_in, enable, busy, done, shadow, sat
  );
endinterface

// File: rtl/reg_cmd_sequencer.sv
// Command sequencer for a 4-function (clear/load/dec/inc) register, issuing timed enable pulses.
// Optional macro SEQ_SATURATE_EN stops INC/DEC at the range limits instead of wrapping.
module reg_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  reg_cmd_sequencer_if.slave bus
);

`ifdef SEQ_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_INC   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       fun_sel_q;
  logic [WIDTH-1:0] data_in_q;
  logic [WIDTH-1:0] shadow_q;
  logic             enable_q;
  logic             busy_q;
  logic             done_q;
  logic             sat_q;
  logic             accept;
  logic [WIDTH-1:0] shadow_nxt;

  function automatic logic [WIDTH-1:0] step_value(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] ld);
    case (op)
      OP_CLEAR: return '0;
      OP_LOAD:  return ld;
      OP_DEC:   return cur - WIDTH'(1);
      default:  return cur + WIDTH'(1);
    endcase
  endfunction

  function automatic logic at_limit(input logic [1:0] op, input logic [WIDTH-1:0] cur);
    return SAT_EN && (((op == OP_INC) && (cur == '1)) || ((op == OP_DEC) && (cur == '0)));
  endfunction

  assign accept        = bus.cmd_valid && (state == IDLE);
  assign bus.cmd_ready = (state == IDLE);
  assign shadow_nxt    = step_value(op_q, shadow_q, data_q);

  assign bus.FunSel  = fun_sel_q;
  assign bus.data_in = data_in_q;
  assign bus.enable  = enable_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.shadow  = shadow_q;
  assign bus.sat     = sat_q;

  // Command capture: only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.cmd_op;
      data_q <= bus.cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_q     <= '0;
      fun_sel_q <= 2'b00;
      data_in_q <= '0;
      shadow_q  <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            sat_q  <= 1'b0;
            if (bus.cmd_op[1] && (bus.cmd_count == '0)) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (bus.cmd_op[1] && at_limit(bus.cmd_op, shadow_q)) begin
              state  <= DONE;
              done_q <= 1'b1;
              sat_q  <= 1'b1;
            end else begin
              state     <= ISSUE;
              enable_q  <= 1'b1;
              fun_sel_q <= bus.cmd_op;
              if (!bus.cmd_op[1]) data_in_q <= bus.cmd_data;
              rem_q     <= bus.cmd_op[1] ? bus.cmd_count - CNT_W'(1) : '0;
            end
          end
        end
        // Shadow follows the downstream register on the edge that ends each pulse;
        // the next step's limit check therefore sees the post-step value.
        ISSUE: begin
          shadow_q <= shadow_nxt;
          if (rem_q == '0) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (at_limit(op_q, shadow_nxt)) begin
            state  <= DONE;
            done_q <= 1'b1;
            sat_q  <= 1'b1;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          state    <= ISSUE;
          enable_q <= 1'b1;
          rem_q    <= rem_q - CNT_W'(1);
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
